// File: rtl/bsg_nand_pkg.sv
// Shared constants and the occupancy state type for the two-entry NAND buffer.
package bsg_nand_pkg;

   localparam int unsigned bsg_nand_fifo_els_gp    = 2;
   localparam int unsigned bsg_nand_count_width_gp = 16;
   localparam logic [15:0] bsg_nand_count_max_gp   = 16'hFFFF;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/bsg_nand_two_fifo_ctrl.sv
// Pointer and occupancy control for the two-entry NAND buffer.
// ready_o and v_o come straight from flops, so no input reaches them combinationally.
module bsg_nand_two_fifo_ctrl
   import bsg_nand_pkg::*;
(
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic v_i,
   input  logic yumi_i,
   output logic enq_o,
   output logic deq_o,
   output logic rd_ptr_o,
   output logic wr_ptr_o,
   output logic ready_o,
   output logic v_o
);

   occ_e occ_q, occ_d;
   logic rd_ptr_q, rd_ptr_d;
   logic wr_ptr_q, wr_ptr_d;
   logic ready_q, ready_d;
   logic v_q, v_d;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         occ_q    <= OCC_EMPTY;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         ready_q  <= 1'b1;
         v_q      <= 1'b0;
      end else begin
         occ_q    <= occ_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         ready_q  <= ready_d;
         v_q      <= v_d;
      end
   end

   // Handshakes are qualified by registered flags; a yumi while empty is dropped.
   always_comb begin
      occ_d    = occ_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      enq_o    = v_i & ready_q;
      deq_o    = yumi_i & v_q;

      if (enq_o) wr_ptr_d = ~wr_ptr_q;
      if (deq_o) rd_ptr_d = ~rd_ptr_q;

      case (occ_q)
         OCC_EMPTY: if (enq_o) occ_d = OCC_ONE;
         OCC_ONE: begin
            if (enq_o && !deq_o)      occ_d = OCC_FULL;
            else if (deq_o && !enq_o) occ_d = OCC_EMPTY;
         end
         OCC_FULL:  if (deq_o) occ_d = OCC_ONE;
         default:   occ_d = OCC_EMPTY;
      endcase

      ready_d = (occ_d != OCC_FULL);
      v_d     = (occ_d != OCC_EMPTY);
   end

   assign rd_ptr_o = rd_ptr_q;
   assign wr_ptr_o = wr_ptr_q;
   assign ready_o  = ready_q;
   assign v_o      = v_q;

endmodule

// File: rtl/bsg_nand_two_fifo.sv
// Two-entry ready/valid buffer storing ~(a & b) on enqueue, presenting results in order.
// Define BSG_NAND_TWO_FIFO_STATS_EN to add the saturating dequeue counter on count_o.
module bsg_nand_two_fifo
   import bsg_nand_pkg::*;
#(
   parameter int unsigned width_p = 16
)(
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] a_i,
   input  logic [width_p-1:0] b_i,
   input  logic               v_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
`ifdef BSG_NAND_TWO_FIFO_STATS_EN
   ,
   output logic [bsg_nand_count_width_gp-1:0] count_o
`endif
);

   logic               enq_w;
   logic               deq_w;
   logic               rd_ptr_w;
   logic               wr_ptr_w;
   logic [width_p-1:0] mem_q [bsg_nand_fifo_els_gp];

   bsg_nand_two_fifo_ctrl ctrl_u (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (v_i),
      .yumi_i    (yumi_i),
      .enq_o     (enq_w),
      .deq_o     (deq_w),
      .rd_ptr_o  (rd_ptr_w),
      .wr_ptr_o  (wr_ptr_w),
      .ready_o   (ready_o),
      .v_o       (v_o)
   );

   // Only the NAND result is stored; slots clear on reset so data_o reads 0.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < int'(bsg_nand_fifo_els_gp); i++) begin
            mem_q[i] <= '0;
         end
      end else if (enq_w) begin
         mem_q[wr_ptr_w] <= ~(a_i & b_i);
      end
   end

   assign data_o = mem_q[rd_ptr_w];

`ifdef BSG_NAND_TWO_FIFO_STATS_EN
   logic [bsg_nand_count_width_gp-1:0] count_q, count_d;

   // Saturating count of dequeued beats.
   always_comb begin
      count_d = count_q;
      if (deq_w && (count_q != bsg_nand_count_max_gp)) begin
         count_d = count_q + bsg_nand_count_width_gp'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) count_q <= '0;
      else            count_q <= count_d;
   end

   assign count_o = count_q;
`else
   logic unused_deq_w;
   assign unused_deq_w = deq_w;
`endif

endmodule

// File: tb/tb_bsg_nand_two_fifo.sv
// Directed bench for bsg_nand_two_fifo: vector table plus streaming and async-reset sequences.
module tb_bsg_nand_two_fifo;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic [15:0] a_i, b_i;
   logic        v_i, yumi_i;
   logic        ready_o, v_o;
   logic [15:0] data_o;
`ifdef BSG_NAND_TWO_FIFO_STATS_EN
   logic [15:0] count_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   bsg_nand_two_fifo #(.width_p(16)) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .v_i       (v_i),
      .ready_o   (ready_o),
      .v_o       (v_o),
      .data_o    (data_o),
      .yumi_i    (yumi_i)
`ifdef BSG_NAND_TWO_FIFO_STATS_EN
      ,
      .count_o   (count_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        v;
      logic [15:0] a;
      logic [15:0] b;
      logic        yumi;
      logic        ready;
      logic        vo;
      logic        chk_data;
      logic [15:0] data;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_count(input string name, input logic [15:0] exp);
`ifdef BSG_NAND_TWO_FIFO_STATS_EN
      check(name, 32'(count_o), 32'(exp));
`else
      if (exp == 16'hFFFF) $display("unexpected count request %s", name);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset_n_i = 1'b0;
      v_i = 1'b0; yumi_i = 1'b0; a_i = '0; b_i = '0;
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;
   endtask

   function automatic vec_t mk(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic yumi, input logic rdy, input logic vo,
                               input logic cd, input logic [15:0] d, input logic [15:0] c);
      vec_t r;
      r.v = v; r.a = a; r.b = b; r.yumi = yumi; r.ready = rdy; r.vo = vo;
      r.chk_data = cd; r.data = d; r.cnt = c;
      return r;
   endfunction

   logic [15:0] exp_q [$];
   logic [15:0] sa, sb, head;

   initial begin
      reset_n_i = 1'b0;
      v_i = 1'b0; yumi_i = 1'b0; a_i = '0; b_i = '0;

      // inputs applied this cycle; expected outputs as seen before the edge
      vecs[0]  = mk(1, 16'hFFFF, 16'h00FF, 0, 1, 0, 1, 16'h0000, 16'd0);
      vecs[1]  = mk(0, 16'h0000, 16'h0000, 0, 1, 1, 1, 16'hFF00, 16'd0);
      vecs[2]  = mk(0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'hFF00, 16'd0);
      vecs[3]  = mk(1, 16'h0F0F, 16'hFFFF, 0, 1, 0, 0, 16'h0000, 16'd1);
      vecs[4]  = mk(1, 16'h1234, 16'hFFFF, 0, 1, 1, 1, 16'hF0F0, 16'd1);
      vecs[5]  = mk(1, 16'hAAAA, 16'h5555, 1, 0, 1, 1, 16'hF0F0, 16'd1);
      vecs[6]  = mk(0, 16'h0000, 16'h0000, 0, 1, 1, 1, 16'hEDCB, 16'd2);
      vecs[7]  = mk(0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'hEDCB, 16'd2);
      vecs[8]  = mk(0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'd3);
      vecs[9]  = mk(1, 16'hFFFF, 16'hFFFF, 0, 1, 0, 0, 16'h0000, 16'd3);
      vecs[10] = mk(1, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h0000, 16'd3);
      vecs[11] = mk(0, 16'h0000, 16'h0000, 0, 1, 1, 1, 16'hFFFF, 16'd4);
      vecs[12] = mk(0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'hFFFF, 16'd4);
      vecs[13] = mk(0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'd5);

      do_reset();
      for (int i = 0; i < 14; i++) begin
         @(negedge clk_i);
         v_i = vecs[i].v; a_i = vecs[i].a; b_i = vecs[i].b; yumi_i = vecs[i].yumi;
         check($sformatf("vec%0d.ready", i), 32'(ready_o), 32'(vecs[i].ready));
         check($sformatf("vec%0d.v", i), 32'(v_o), 32'(vecs[i].vo));
         if (vecs[i].chk_data)
            check($sformatf("vec%0d.data", i), 32'(data_o), 32'(vecs[i].data));
         check_count($sformatf("vec%0d.count", i), vecs[i].cnt);
      end

      // streaming: v_i and yumi_i held high for 100 beats
      do_reset();
      for (int i = 0; i <= 100; i++) begin
         @(negedge clk_i);
         check($sformatf("stream%0d.ready", i), 32'(ready_o), 32'd1);
         if (exp_q.size() != 0) begin
            head = exp_q.pop_front();
            check($sformatf("stream%0d.v", i), 32'(v_o), 32'd1);
            check($sformatf("stream%0d.data", i), 32'(data_o), 32'(head));
         end else begin
            check($sformatf("stream%0d.v", i), 32'(v_o), 32'd0);
         end
         yumi_i = 1'b1;
         if (i < 100) begin
            sa = 16'(i * 37 + 1);
            sb = 16'hF0F3 ^ 16'(i);
            v_i = 1'b1; a_i = sa; b_i = sb;
            exp_q.push_back(~(sa & sb));
         end else begin
            v_i = 1'b0;
         end
      end
      @(negedge clk_i);
      yumi_i = 1'b0;
      check("stream.drained_v", 32'(v_o), 32'd0);
      check_count("stream.count", 16'd100);

      // fill to full, then assert reset between clock edges
      do_reset();
      @(negedge clk_i);
      v_i = 1'b1; a_i = 16'h0F0F; b_i = 16'hFFFF;
      @(negedge clk_i);
      a_i = 16'h1234; b_i = 16'hFFFF;
      @(negedge clk_i);
      v_i = 1'b0;
      check("full.ready", 32'(ready_o), 32'd0);
      check("full.v", 32'(v_o), 32'd1);
      check("full.data", 32'(data_o), 32'h0000F0F0);
      #2;
      reset_n_i = 1'b0;
      #1;
      check("async_rst.v", 32'(v_o), 32'd0);
      check("async_rst.ready", 32'(ready_o), 32'd1);
      check("async_rst.data", 32'(data_o), 32'd0);
      check_count("async_rst.count", 16'd0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(negedge clk_i);
      v_i = 1'b1; a_i = 16'hC3C3; b_i = 16'hF00F;
      @(negedge clk_i);
      v_i = 1'b0;
      check("post_rst.v", 32'(v_o), 32'd1);
      check("post_rst.data", 32'(data_o), 32'h00003FFC);
      check("post_rst.ready", 32'(ready_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bsg_nand_two_fifo.md
# bsg_nand_two_fifo

Two-entry ready/valid buffer that sits directly upstream of the bitwise NAND consumer stage. It accepts operand pairs, computes the bitwise NAND on enqueue, and stores only the result. It presents results in order on a valid/yumi output. It decouples the producer's backpressure from the consumer and gives a registered, one-cycle-latency NAND stream.

## Interface
- width_p, default 16: operand and result width in bits; minimum 1.
- clk_i  input  1  sole clock; all state updates on the rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- a_i  input  width_p  operand A.
- b_i  input  width_p  operand B.
- v_i  input  1  input valid; a_i/b_i are meaningful when high.
- ready_o  output  1  buffer can accept this cycle.
- v_o  output  1  data_o holds a valid result.
- data_o  output  width_p  head-of-queue result, equal to ~(a & b) of the oldest accepted pair.
- yumi_i  input  1  consumer takes data_o this cycle; legal only when v_o is high.
- count_o  output  16  dequeued-beat count; present only when BSG_NAND_TWO_FIFO_STATS_EN is defined.

## Operation
- Enqueue: enq = v_i & ready_o. On enq, the slot at wr_ptr is written with ~(a_i & b_i), and wr_ptr toggles.
- Dequeue: deq = yumi_i & v_o. On deq, rd_ptr toggles.
- ready_o = ~full. v_o = ~empty. data_o = mem[rd_ptr], read combinationally from the register.
- Occupancy flags:
  - full sets on enq without deq when one entry is held.
  - empty sets on deq without enq when one entry is held.
  - enq and deq in the same cycle leave occupancy unchanged.
- Full with yumi_i: no enqueue that cycle, because ready_o = 0. There is no pass-through of a freed slot.
- Empty with v_i: entry written; v_o rises the next cycle. There is no combinational bypass.
- yumi_i while v_o = 0 is a protocol violation. The block ignores it: no pointer or count change.
- v_i while ready_o = 0 is legal. The producer holds operands; nothing is written.
- Order is strictly FIFO. There is no reordering or drop.

## Timing
- Reset assertion, asynchronous:
  - rd_ptr = wr_ptr = 0, full = 0, empty = 1.
  - Both storage slots are cleared to 0.
  - Outputs: v_o = 0, ready_o = 1, data_o = 0, count_o = 0.
- Reset deassertion must be synchronised to clk_i externally.
- Reset mid-operation discards all held entries immediately, without waiting for a clock edge.
- Latency: a pair accepted at edge N appears on data_o with v_o = 1 after edge N. It is consumable in cycle N+1.
- Throughput: one beat per cycle sustained when yumi_i is asserted every cycle that v_o is high.
- ready_o and v_o depend only on registered state. There is no combinational path from v_i or yumi_i to any output.

## Configuration
- BSG_NAND_TWO_FIFO_STATS_EN defined:
  - count_o port exists.
  - A 16-bit counter increments on each deq.
  - The counter saturates at 16'hFFFF and resets to 0.
- BSG_NAND_TWO_FIFO_STATS_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package bsg_nand_pkg holds the following shared constants:
  - bsg_nand_fifo_els_gp = 2.
  - bsg_nand_count_width_gp = 16.
  - bsg_nand_count_max_gp = 16'hFFFF.
- Sub-module bsg_nand_two_fifo_ctrl holds the control state:
  - rd_ptr, wr_ptr, full and empty.
  - Outputs enq_o and deq_o from v_i and yumi_i.
- The top level holds the storage, the NAND on the write path, and the optional counter.

## Test plan
- Reset, then v_i = 1 with a_i = 16'hFFFF, b_i = 16'h00FF -> one cycle later v_o = 1, data_o = 16'hFF00.
- Enqueue 16'h0F0F/16'hFFFF, then 16'h1234/16'hFFFF, with yumi_i = 0 -> ready_o = 0 after the second write. Outputs are 16'hF0F0 then 16'hEDCB, in order, as yumi_i is pulsed.
- Full, with v_i = 1 and yumi_i = 1 in the same cycle -> no write; the next cycle shows one entry, ready_o = 1, and the second result at the head.
- Streaming 100 beats with v_i and yumi_i held high -> 100 results, correct order, no bubbles after the first. count_o = 100 with STATS_EN.
- yumi_i = 1 while empty -> no state change, and count_o stays at 0.
- Assert reset_n_i low mid-clock while full -> v_o = 0, ready_o = 1, data_o = 0 immediately. The first post-reset enqueue returns the correct result.
